// File: rtl/spi_note_tx.sv
`timescale 1ns/1ps
// spi_note_tx
// Serialises one frame of NUM_TRACKS note packets (24 bits each, track
// NUM_TRACKS-1 first, MSB first) onto an SPI-style link. A frame is framed
// by chipSelect: sck toggles every CLK_DIV clk cycles while data is sent.
// chipSelect then stays high for a CLK_DIV tail and low for a CLK_DIV gap.
// After the gap, done pulses for one cycle.
//
// Ports
//   clk         system clock, all state changes on its rising edge
//   reset       synchronous active-low reset
//   start       frame request, only looked at while idle
//   notePackets frame payload, captured when start is accepted
//   busy        high whenever a frame is in progress (any non-idle state)
//   done        one-cycle pulse when a frame has fully completed
//   chipSelect  active-high frame strobe
//   sck         serial clock, receiver samples on its rising edge
//   sdo         serial data, MSB first
module spi_note_tx #(
  parameter int NUM_TRACKS = 4,
  parameter int CLK_DIV    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [24*NUM_TRACKS-1:0] notePackets,
  output logic                     busy,
  output logic                     done,
  output logic                     chipSelect,
  output logic                     sck,
  output logic                     sdo
);

  localparam int B  = 24 * NUM_TRACKS;
  localparam int BW = $clog2(B);
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, TAIL, GAP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   half_cnt, half_n;
  logic [BW-1:0]   bit_cnt, bit_n;
  logic [B-1:0]    shreg, shreg_n;
  logic            cs_n, sck_n, done_n, busy_n;
  logic            half_last, bit_last;

  assign half_last = (half_cnt == CW'(CLK_DIV - 1));
  assign bit_last  = (bit_cnt == BW'(B - 1));

  // sdo is the top bit of the shift register, so it is a flop output. The
  // final shift out of HIGH on the last bit leaves the register all zero,
  // which gives sdo=0 during TAIL and GAP without extra logic.
  assign sdo = shreg[B-1];

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_n = state;
    half_n  = half_last ? '0 : half_cnt + CW'(1);
    bit_n   = bit_cnt;
    shreg_n = shreg;
    cs_n    = chipSelect;
    sck_n   = sck;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        half_n = '0;
        if (start) begin
          state_n = LOW;
          shreg_n = notePackets;
          bit_n   = '0;
          cs_n    = 1'b1;
          sck_n   = 1'b0;
        end
      end
      LOW: begin
        if (half_last) begin
          state_n = HIGH;
          sck_n   = 1'b1;
        end
      end
      HIGH: begin
        if (half_last) begin
          sck_n   = 1'b0;
          shreg_n = {shreg[B-2:0], 1'b0};
          if (bit_last) begin
            state_n = TAIL;
            bit_n   = '0;
          end else begin
            state_n = LOW;
            bit_n   = bit_cnt + BW'(1);
          end
        end
      end
      TAIL: begin
        if (half_last) begin
          state_n = GAP;
          cs_n    = 1'b0;
        end
      end
      GAP: begin
        if (half_last) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      // NOTE: the shift register is reset too, so sdo is a defined 0 out of
      // reset and after an abandoned frame.
      shreg      <= '0;
      chipSelect <= 1'b0;
      sck        <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      half_cnt   <= half_n;
      bit_cnt    <= bit_n;
      shreg      <= shreg_n;
      chipSelect <= cs_n;
      sck        <= sck_n;
      done       <= done_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_spi_note_tx.sv
`timescale 1ns/1ps
// tb_spi_note_tx
// Directed bench for spi_note_tx. Instance a uses the default parameters
// (96-bit frames, CLK_DIV=4); instance b uses NUM_TRACKS=1, CLK_DIV=2.
// Negedge monitors act as the SPI receiver: they capture sdo on each sck
// rise and timestamp chipSelect falls and done pulses in posedge counts.
module tb_spi_note_tx;

  localparam logic [95:0] F1 = 96'h012345_6789AB_CDEF01_234567;
  localparam logic [95:0] F2 = {4{24'h0400FF}};
  localparam logic [95:0] F3 = 96'hA5A5A5_5A5A5A_F0F0F0_0F0F0F;
  localparam logic [23:0] FB = 24'hC35A96;

  logic        clk = 1'b0;
  logic        reset_a, start_a, busy_a, done_a, cs_a, sck_a, sdo_a;
  logic [95:0] notes_a;
  logic        reset_b, start_b, busy_b, done_b, cs_b, sck_b, sdo_b;
  logic [23:0] notes_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int e0_a, e0_b;

  spi_note_tx dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .notePackets(notes_a),
    .busy(busy_a), .done(done_a), .chipSelect(cs_a), .sck(sck_a), .sdo(sdo_a)
  );

  spi_note_tx #(.NUM_TRACKS(1), .CLK_DIV(2)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .notePackets(notes_b),
    .busy(busy_b), .done(done_b), .chipSelect(cs_b), .sck(sck_b), .sdo(sdo_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model / monitor for instance a
  logic        sck_qa = 1'b0, cs_qa = 1'b0, busy_qa = 1'b0;
  logic [95:0] cap_a = '0;
  int rise_a = 0, frise_a = 0, first_rise_a = 0, last_rise_a = 0, bad_a = 0;
  int cs_fall_a = 0, done_cnt_a = 0, done_cyc_a = 0;
  int cs_low_a = 0, cs_low_run_a = 0, busy_low_a = 0, busy_low_run_a = 0;
  logic done_busy_a = 1'b0;

  always @(negedge clk) begin
    sck_qa  <= sck_a;
    cs_qa   <= cs_a;
    busy_qa <= busy_a;
    if (sck_a && !sck_qa) begin
      if (cs_a) begin
        rise_a  <= rise_a + 1;
        cap_a   <= {cap_a[94:0], sdo_a};
        frise_a <= frise_a + 1;
        if (frise_a == 0) first_rise_a <= cyc;
        last_rise_a <= cyc;
      end else begin
        bad_a <= bad_a + 1;
      end
    end else if (!cs_a && !cs_qa && sck_a != sck_qa) begin
      bad_a <= bad_a + 1;
    end
    if (cs_a && !cs_qa) begin
      frise_a      <= 0;
      cs_low_run_a <= cs_low_a;
    end
    if (!cs_a && cs_qa) cs_fall_a <= cyc;
    cs_low_a <= cs_a ? 0 : cs_low_a + 1;
    if (busy_a && !busy_qa) busy_low_run_a <= busy_low_a;
    busy_low_a <= busy_a ? 0 : busy_low_a + 1;
    if (done_a) begin
      done_cnt_a  <= done_cnt_a + 1;
      done_cyc_a  <= cyc;
      done_busy_a <= busy_a;
    end
  end

  // Receiver model / monitor for instance b
  logic        sck_qb = 1'b0, cs_qb = 1'b0;
  logic [23:0] cap_b = '0;
  int rise_b = 0, frise_b = 0, first_rise_b = 0, last_rise_b = 0;
  int spacing_bad_b = 0, cs_fall_b = 0, done_cnt_b = 0, done_cyc_b = 0;

  always @(negedge clk) begin
    sck_qb <= sck_b;
    cs_qb  <= cs_b;
    if (sck_b && !sck_qb && cs_b) begin
      rise_b  <= rise_b + 1;
      cap_b   <= {cap_b[22:0], sdo_b};
      frise_b <= frise_b + 1;
      if (frise_b == 0) first_rise_b <= cyc;
      else if (cyc - last_rise_b != 4) spacing_bad_b <= spacing_bad_b + 1;
      last_rise_b <= cyc;
    end
    if (cs_b && !cs_qb) frise_b <= 0;
    if (!cs_b && cs_qb) cs_fall_b <= cyc;
    if (done_b) begin
      done_cnt_b <= done_cnt_b + 1;
      done_cyc_b <= cyc;
    end
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept a frame on instance a; e0_a is the accepting posedge index.
  task automatic send_a(input logic [95:0] d);
    @(negedge clk);
    notes_a = d;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    e0_a    = cyc;
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int target);
    for (int i = 0; i < 3000 && done_cnt_a < target; i++) @(posedge clk);
    #1;
  endtask

  // Full frame on instance a with all timing and content checks.
  task automatic frame_a(input string tag, input logic [95:0] d);
    int r0, d0, b0;
    r0 = rise_a;
    d0 = done_cnt_a;
    b0 = bad_a;
    send_a(d);
    check({tag, "_cs_e0"},   96'(cs_a), 96'd1);
    check({tag, "_sdo_e0"},  96'(sdo_a), 96'(d[95]));
    check({tag, "_busy_e0"}, 96'(busy_a), 96'd1);
    notes_a = ~d;
    wait_done_a(d0 + 1);
    check({tag, "_done_cnt"},   96'(done_cnt_a - d0), 96'd1);
    check({tag, "_rises"},      96'(rise_a - r0), 96'd96);
    check({tag, "_bits"},       cap_a, d);
    check({tag, "_first_rise"}, 96'(first_rise_a), 96'(e0_a + 4));
    check({tag, "_last_rise"},  96'(last_rise_a), 96'(e0_a + 764));
    check({tag, "_cs_fall"},    96'(cs_fall_a), 96'(e0_a + 772));
    check({tag, "_done_cyc"},   96'(done_cyc_a), 96'(e0_a + 776));
    check({tag, "_done_busy"},  96'(done_busy_a), 96'd0);
    check({tag, "_sck_cs_low"}, 96'(bad_a - b0), 96'd0);
  endtask

  initial begin
    int r0, d0;
    reset_a = 1'b0;
    reset_b = 1'b0;
    start_a = 1'b1;
    start_b = 1'b0;
    notes_a = F1;
    notes_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 96'(busy_a), 96'd0);
    check("rst_cs",   96'(cs_a), 96'd0);
    check("rst_sck",  96'(sck_a), 96'd0);
    check("rst_sdo",  96'(sdo_a), 96'd0);
    check("rst_done", 96'(done_a), 96'd0);
    @(negedge clk);
    reset_a = 1'b1;
    reset_b = 1'b1;
    start_a = 1'b0;
    @(posedge clk);
    #1;
    check("start_in_rst_ignored", 96'(busy_a), 96'd0);

    // Reference frame; payload input is scrambled right after acceptance.
    frame_a("f1", F1);

    // Payload change and start pulse at bit 40 must not disturb the frame.
    r0 = rise_a;
    d0 = done_cnt_a;
    send_a(F2);
    for (int i = 0; i < 2000 && rise_a - r0 < 40; i++) @(posedge clk);
    @(negedge clk);
    notes_a = ~F2;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(d0 + 1);
    check("mid_rises", 96'(rise_a - r0), 96'd96);
    check("mid_bits",  cap_a, F2);
    repeat (30) @(posedge clk);
    #1;
    check("mid_no_queue_busy", 96'(busy_a), 96'd0);
    check("mid_single_done",   96'(done_cnt_a - d0), 96'd1);

    // Reset pulse at bit 50 abandons the frame without done.
    r0 = rise_a;
    d0 = done_cnt_a;
    send_a(F1);
    for (int i = 0; i < 2000 && rise_a - r0 < 50; i++) @(posedge clk);
    @(negedge clk);
    reset_a = 1'b0;
    @(posedge clk);
    #1;
    check("abort_cs",   96'(cs_a), 96'd0);
    check("abort_sck",  96'(sck_a), 96'd0);
    check("abort_busy", 96'(busy_a), 96'd0);
    @(negedge clk);
    reset_a = 1'b1;
    repeat (800) @(posedge clk);
    #1;
    check("abort_no_done", 96'(done_cnt_a - d0), 96'd0);
    frame_a("after_abort", F3);

    // Silence is a normal frame.
    frame_a("silence", '0);

    // start held high: three frames, 5-cycle cs gap, 1-cycle busy gap.
    r0 = rise_a;
    d0 = done_cnt_a;
    @(negedge clk);
    notes_a = F1;
    start_a = 1'b1;
    for (int i = 0; i < 3000 && done_cnt_a < d0 + 2; i++) @(posedge clk);
    #1;
    start_a = 1'b0;
    wait_done_a(d0 + 3);
    check("b2b_done_cnt", 96'(done_cnt_a - d0), 96'd3);
    check("b2b_rises",    96'(rise_a - r0), 96'd288);
    check("b2b_cs_gap",   96'(cs_low_run_a), 96'd5);
    check("b2b_busy_gap", 96'(busy_low_run_a), 96'd1);
    check("b2b_bits",     cap_a, F1);
    repeat (20) @(posedge clk);
    #1;
    check("b2b_stops", 96'(busy_a), 96'd0);

    // Small configuration: 24 bits, CLK_DIV=2.
    r0 = rise_b;
    d0 = done_cnt_b;
    @(negedge clk);
    notes_b = FB;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    e0_b    = cyc;
    start_b = 1'b0;
    notes_b = ~FB;
    for (int i = 0; i < 500 && done_cnt_b < d0 + 1; i++) @(posedge clk);
    #1;
    check("b_done_cnt",   96'(done_cnt_b - d0), 96'd1);
    check("b_rises",      96'(rise_b - r0), 96'd24);
    check("b_bits",       96'(cap_b), 96'(FB));
    check("b_first_rise", 96'(first_rise_b), 96'(e0_b + 2));
    check("b_last_rise",  96'(last_rise_b), 96'(e0_b + 94));
    check("b_spacing",    96'(spacing_bad_b), 96'd0);
    check("b_cs_fall",    96'(cs_fall_b), 96'(e0_b + 98));
    check("b_done_cyc",   96'(done_cyc_b), 96'(e0_b + 100));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_note_tx.md
SPI_NOTE_TX -- requirements
Module: spi_note_tx

Interface
REQ-001 Parameter NUM_TRACKS, default 4, number of 24-bit track packets per frame.
REQ-002 Parameter CLK_DIV, default 4, sck half-period in clk cycles; legal range 2..255.
REQ-003 clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset), sampled on posedge clk.
REQ-005 start  input  1  request to transmit one frame; sampled only in IDLE.
REQ-006 notePackets  input  24*NUM_TRACKS  frame data; per track {tuneWord[15:0], volume[7:0]}; track NUM_TRACKS-1 in the top 24 bits.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse when a frame completes.
REQ-009 chipSelect  output  1  active-high frame strobe to the receiver.
REQ-010 sck  output  1  serial clock; the receiver samples on its rising edge.
REQ-011 sdo  output  1  serial data to the receiver's sdi, MSB first.

Function
REQ-012 The block SHALL define B = 24*NUM_TRACKS bits per frame and E0 = the posedge at which start is accepted.
REQ-013 The FSM SHALL have states IDLE, LOW, HIGH, TAIL and GAP, plus a half-period counter (0..CLK_DIV-1) and a bit counter (0..B-1).
REQ-014 IDLE: when start=1, the block SHALL latch notePackets into a B-bit shift register and enter LOW, with chipSelect=1, sck=0 and sdo=notePackets[B-1] after E0.
REQ-015 Changes on notePackets after E0 SHALL NOT affect the frame in flight.
REQ-016 LOW: after CLK_DIV cycles the block SHALL enter HIGH with sck=1; sdo SHALL be stable for the whole LOW and HIGH pair.
REQ-017 HIGH: after CLK_DIV cycles, if bits remain, the block SHALL enter LOW with sck=0, shift left one bit and put the next bit on sdo.
REQ-018 HIGH: after CLK_DIV cycles on the last bit, the block SHALL enter TAIL with sck=0 and sdo=0.
REQ-019 The rising edge of sck for transmit bit k (k=0..B-1) SHALL occur after edge E0+(2k+1)*CLK_DIV.
REQ-020 TAIL: chipSelect SHALL stay 1 for CLK_DIV cycles, then the block SHALL enter GAP with chipSelect=0.
REQ-021 GAP: after CLK_DIV cycles with chipSelect=0, the block SHALL return to IDLE, pulse done=1 for exactly one cycle and drop busy in that same cycle.
REQ-022 chipSelect SHALL fall after edge E0+(2B+1)*CLK_DIV; done SHALL be high in the cycle after edge E0+(2B+2)*CLK_DIV.
REQ-023 For defaults (B=96, CLK_DIV=4) these are E0+772 and E0+776.
REQ-024 start while busy=1 SHALL be ignored, not queued.
REQ-025 start=1 in the cycle done=1 SHALL be accepted, so back-to-back frames are separated by exactly CLK_DIV+1 cycles of chipSelect=0.
REQ-026 Exactly B rising sck edges SHALL occur per frame, all while chipSelect=1, so the receiver's bit count equals B exactly.
REQ-027 No sck edge SHALL occur while chipSelect=0.
REQ-028 An all-zero frame (silence) SHALL be transmitted like any other frame.
REQ-029 sck, chipSelect, sdo, busy and done SHALL all be registered outputs.

Reset
REQ-030 While reset=0, the block SHALL go to IDLE with chipSelect=0, sck=0, sdo=0, busy=0, done=0, both counters 0 and the shift register 0.
REQ-031 Reset mid-frame SHALL deassert chipSelect and sck at the next posedge; the partial frame is abandoned, with no done pulse.
REQ-032 start sampled in the same cycle as reset=0 SHALL be ignored.
REQ-033 The first frame after reset release SHALL follow REQ-014 exactly.

Verification
REQ-034 Defaults; notePackets = 0x0123_45 | 0x6789_AB | 0xCDEF_01 | 0x2345_67 (track 3..0); one start pulse -> exactly 96 sck rising edges; bits captured at rising sck equal 0x012345_6789AB_CDEF01_234567; chipSelect falls at E0+772; done at E0+776.
REQ-035 Loopback: connect to the existing SPI receiver; send tuneWord=0x0400, volume=0xFF on all tracks -> receiver notePackets match within 4 clk cycles after chipSelect falls.
REQ-036 start held high continuously -> frames repeat with a 5-cycle chipSelect-low gap; busy is low for exactly 1 cycle per frame.
REQ-037 Mid-frame, toggle notePackets and pulse start at bit 40 -> transmitted bits unchanged, no second frame, a single done pulse.
REQ-038 reset=0 for 1 cycle at bit 50 -> chipSelect=0, sck=0 next cycle; no done pulse; the next start produces a full, correct 96-bit frame.
REQ-039 CLK_DIV=2, NUM_TRACKS=1 -> 24 rising sck edges spaced 4 cycles apart; chipSelect falls at E0+98; done at E0+100.
